// File: rtl/getir_istek_denetleyici.sv
`default_nettype none
// ---------------------------------------------------------------------------
// getir_istek_denetleyici : fetch request scheduler between fetch stage 1 and
// the L1 instruction cache, with in-order PC tagging and flush draining.
// Revision: 1.0
// ---------------------------------------------------------------------------
module getir_istek_denetleyici #(
  parameter int PS_BIT        = 32,
  parameter int VERI_BIT      = 32,
  parameter int MAKS_BEKLEYEN = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [PS_BIT-1:0]                      g1_istek_ps_i,
  input  logic                                   g1_istek_gecerli_i,
  output logic                                   g1_istek_hazir_o,
  output logic [PS_BIT-1:0]                      l1b_istek_ps_o,
  output logic                                   l1b_istek_gecerli_o,
  input  logic                                   l1b_istek_hazir_i,
  input  logic [VERI_BIT-1:0]                    l1b_yanit_veri_i,
  input  logic                                   l1b_yanit_gecerli_i,
  output logic                                   l1b_yanit_hazir_o,
  output logic [VERI_BIT-1:0]                    g2_buyruk_o,
  output logic [PS_BIT-1:0]                      g2_ps_o,
  output logic                                   g2_gecerli_o,
  input  logic                                   g2_hazir_i,
  input  logic                                   bosalt_i,
  output logic [$clog2(MAKS_BEKLEYEN+1)-1:0]     bekleyen_sayisi_o
);

  localparam int SAY_BIT = $clog2(MAKS_BEKLEYEN + 1);
  localparam int IS_BIT  = $clog2(MAKS_BEKLEYEN);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    BEKLE  = 2'd1,
    BOSALT = 2'd2
  } durum_e;

  durum_e                durum_q, durum_d;
  logic [SAY_BIT-1:0]    bekleyen_q, bekleyen_d;
  logic [SAY_BIT-1:0]    bayat_q, bayat_d;
  logic [IS_BIT-1:0]     yaz_is_q, yaz_is_d;
  logic [IS_BIT-1:0]     oku_is_q, oku_is_d;
  logic                  g2_gecerli_q, g2_gecerli_d;
  logic [VERI_BIT-1:0]   g2_buyruk_q, g2_buyruk_d;
  logic [PS_BIT-1:0]     g2_ps_q, g2_ps_d;
  logic [PS_BIT-1:0]     etiket_q [MAKS_BEKLEYEN];

  logic dolu;
  logic istek_ates;
  logic yanit_ates;
  logic yanit_at;

  always_comb begin
    dolu                = (bekleyen_q == SAY_BIT'(MAKS_BEKLEYEN));
    l1b_istek_ps_o      = g1_istek_ps_i;
    l1b_istek_gecerli_o = g1_istek_gecerli_i & ~dolu & ~bosalt_i;
    g1_istek_hazir_o    = l1b_istek_hazir_i & ~dolu & ~bosalt_i;
    istek_ates          = l1b_istek_gecerli_o & l1b_istek_hazir_i;

    // The state register mirrors the counters: BOSTA <=> nothing outstanding,
    // BOSALT <=> stale responses still owed.
    l1b_yanit_hazir_o = (durum_q != BOSTA) &
                        (bosalt_i | (durum_q == BOSALT) | ~g2_gecerli_q | g2_hazir_i);
    yanit_ates        = l1b_yanit_gecerli_i & l1b_yanit_hazir_o;
    yanit_at          = yanit_ates & (bosalt_i | (durum_q == BOSALT));

    bekleyen_d = bekleyen_q + SAY_BIT'(istek_ates) - SAY_BIT'(yanit_ates);
    yaz_is_d   = yaz_is_q + IS_BIT'(istek_ates);
    oku_is_d   = oku_is_q + IS_BIT'(yanit_ates);

    bayat_d = bayat_q;
    if (bosalt_i) begin
      bayat_d = bekleyen_q - SAY_BIT'(yanit_ates);
    end else if (yanit_ates && (durum_q == BOSALT)) begin
      bayat_d = bayat_q - SAY_BIT'(1);
    end

    g2_gecerli_d = g2_gecerli_q;
    g2_buyruk_d  = g2_buyruk_q;
    g2_ps_d      = g2_ps_q;
    if (yanit_ates && !yanit_at) begin
      g2_gecerli_d = 1'b1;
      g2_buyruk_d  = l1b_yanit_veri_i;
      g2_ps_d      = etiket_q[oku_is_q];
    end else if (bosalt_i || g2_hazir_i) begin
      g2_gecerli_d = 1'b0;
    end

    if (bekleyen_d == '0) begin
      durum_d = BOSTA;
    end else if (bayat_d != '0) begin
      durum_d = BOSALT;
    end else begin
      durum_d = BEKLE;
    end

    g2_gecerli_o      = g2_gecerli_q;
    g2_buyruk_o       = g2_buyruk_q;
    g2_ps_o           = g2_ps_q;
    bekleyen_sayisi_o = bekleyen_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q      <= BOSTA;
      bekleyen_q   <= '0;
      bayat_q      <= '0;
      yaz_is_q     <= '0;
      oku_is_q     <= '0;
      g2_gecerli_q <= 1'b0;
      g2_buyruk_q  <= '0;
      g2_ps_q      <= '0;
    end else begin
      durum_q      <= durum_d;
      bekleyen_q   <= bekleyen_d;
      bayat_q      <= bayat_d;
      yaz_is_q     <= yaz_is_d;
      oku_is_q     <= oku_is_d;
      g2_gecerli_q <= g2_gecerli_d;
      g2_buyruk_q  <= g2_buyruk_d;
      g2_ps_q      <= g2_ps_d;
    end
  end

  // Tag storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (istek_ates) begin
      etiket_q[yaz_is_q] <= g1_istek_ps_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_getir_istek_denetleyici.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_getir_istek_denetleyici : directed self-checking bench for the fetch
// request scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_getir_istek_denetleyici;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] g1_istek_ps_i;
  logic        g1_istek_gecerli_i;
  logic        g1_istek_hazir_o;
  logic [31:0] l1b_istek_ps_o;
  logic        l1b_istek_gecerli_o;
  logic        l1b_istek_hazir_i;
  logic [31:0] l1b_yanit_veri_i;
  logic        l1b_yanit_gecerli_i;
  logic        l1b_yanit_hazir_o;
  logic [31:0] g2_buyruk_o;
  logic [31:0] g2_ps_o;
  logic        g2_gecerli_o;
  logic        g2_hazir_i;
  logic        bosalt_i;
  logic [2:0]  bekleyen_sayisi_o;

  int checks   = 0;
  int failures = 0;

  getir_istek_denetleyici #(
    .PS_BIT(32), .VERI_BIT(32), .MAKS_BEKLEYEN(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .g1_istek_ps_i(g1_istek_ps_i), .g1_istek_gecerli_i(g1_istek_gecerli_i),
    .g1_istek_hazir_o(g1_istek_hazir_o),
    .l1b_istek_ps_o(l1b_istek_ps_o), .l1b_istek_gecerli_o(l1b_istek_gecerli_o),
    .l1b_istek_hazir_i(l1b_istek_hazir_i),
    .l1b_yanit_veri_i(l1b_yanit_veri_i), .l1b_yanit_gecerli_i(l1b_yanit_gecerli_i),
    .l1b_yanit_hazir_o(l1b_yanit_hazir_o),
    .g2_buyruk_o(g2_buyruk_o), .g2_ps_o(g2_ps_o), .g2_gecerli_o(g2_gecerli_o),
    .g2_hazir_i(g2_hazir_i), .bosalt_i(bosalt_i),
    .bekleyen_sayisi_o(bekleyen_sayisi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic adim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic istek_ver(input logic [31:0] ps);
    g1_istek_gecerli_i = 1'b1;
    g1_istek_ps_i      = ps;
    adim();
    g1_istek_gecerli_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    g1_istek_ps_i = 32'h0; g1_istek_gecerli_i = 1'b0; l1b_istek_hazir_i = 1'b1;
    l1b_yanit_veri_i = 32'h0; l1b_yanit_gecerli_i = 1'b1; g2_hazir_i = 1'b1; bosalt_i = 1'b0;
    #2;
    checks++; if (g2_gecerli_o !== 1'b0) begin failures++; $display("FAIL rst_g2_gecerli: got %b expected 0", g2_gecerli_o); end
    checks++; if (g2_buyruk_o !== 32'h0) begin failures++; $display("FAIL rst_g2_buyruk: got %h expected 0", g2_buyruk_o); end
    checks++; if (g2_ps_o !== 32'h0) begin failures++; $display("FAIL rst_g2_ps: got %h expected 0", g2_ps_o); end
    checks++; if (bekleyen_sayisi_o !== 3'd0) begin failures++; $display("FAIL rst_bekleyen: got %0d expected 0", bekleyen_sayisi_o); end
    checks++; if (l1b_yanit_hazir_o !== 1'b0) begin failures++; $display("FAIL rst_yanit_hazir: got %b expected 0", l1b_yanit_hazir_o); end
    l1b_yanit_gecerli_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    adim();
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    logic [31:0] dat [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    dat[0] = 32'hD000_0000; dat[1] = 32'hD111_1111; dat[2] = 32'hD222_2222;
    g1_istek_gecerli_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      g1_istek_ps_i = pcs[i];
      #1;
      checks++; if (g1_istek_hazir_o !== 1'b1 || l1b_istek_gecerli_o !== 1'b1 || l1b_istek_ps_o !== pcs[i]) begin
        failures++; $display("FAIL basic_issue%0d: got hazir=%b gecerli=%b ps=%h expected 1 1 %h", i, g1_istek_hazir_o, l1b_istek_gecerli_o, l1b_istek_ps_o, pcs[i]); end
      adim();
    end
    g1_istek_gecerli_i = 1'b0;
    checks++; if (bekleyen_sayisi_o !== 3'd3) begin failures++; $display("FAIL basic_bekleyen3: got %0d expected 3", bekleyen_sayisi_o); end
    g2_hazir_i = 1'b1;
    l1b_yanit_gecerli_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      l1b_yanit_veri_i = dat[i];
      #1;
      checks++; if (l1b_yanit_hazir_o !== 1'b1) begin failures++; $display("FAIL basic_yanit_hazir%0d: got %b expected 1", i, l1b_yanit_hazir_o); end
      adim();
      checks++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== pcs[i] || g2_buyruk_o !== dat[i]) begin
        failures++; $display("FAIL basic_out%0d: got v=%b ps=%h d=%h expected 1 %h %h", i, g2_gecerli_o, g2_ps_o, g2_buyruk_o, pcs[i], dat[i]); end
    end
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (bekleyen_sayisi_o !== 3'd0) begin failures++; $display("FAIL basic_bekleyen0: got %0d expected 0", bekleyen_sayisi_o); end
    adim();
    checks++; if (g2_gecerli_o !== 1'b0) begin failures++; $display("FAIL basic_consume_clear: got %b expected 0", g2_gecerli_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) istek_ver(32'h300 + 32'(4 * i));
    checks++; if (bekleyen_sayisi_o !== 3'd4) begin failures++; $display("FAIL full_bekleyen4: got %0d expected 4", bekleyen_sayisi_o); end
    g1_istek_gecerli_i = 1'b1; g1_istek_ps_i = 32'h310;
    l1b_yanit_gecerli_i = 1'b1; l1b_yanit_veri_i = 32'hF000_0000; g2_hazir_i = 1'b1;
    #1;
    checks++; if (g1_istek_hazir_o !== 1'b0 || l1b_istek_gecerli_o !== 1'b0) begin
      failures++; $display("FAIL full_blocked: got hazir=%b gecerli=%b expected 0 0", g1_istek_hazir_o, l1b_istek_gecerli_o); end
    checks++; if (l1b_yanit_hazir_o !== 1'b1) begin failures++; $display("FAIL full_yanit_hazir: got %b expected 1", l1b_yanit_hazir_o); end
    adim();
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (bekleyen_sayisi_o !== 3'd3 || g2_ps_o !== 32'h300) begin
      failures++; $display("FAIL full_after_resp: got cnt=%0d ps=%h expected 3 300", bekleyen_sayisi_o, g2_ps_o); end
    #1;
    checks++; if (g1_istek_hazir_o !== 1'b1 || l1b_istek_gecerli_o !== 1'b1) begin
      failures++; $display("FAIL full_resume: got hazir=%b gecerli=%b expected 1 1", g1_istek_hazir_o, l1b_istek_gecerli_o); end
    adim();
    g1_istek_gecerli_i = 1'b0;
    l1b_yanit_gecerli_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      l1b_yanit_veri_i = 32'hF000_0000 + 32'(i);
      adim();
      checks++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h300 + 32'(4 * i) || g2_buyruk_o !== 32'hF000_0000 + 32'(i)) begin
        failures++; $display("FAIL full_drain%0d: got v=%b ps=%h d=%h expected 1 %h %h", i, g2_gecerli_o, g2_ps_o, g2_buyruk_o, 32'h300 + 32'(4 * i), 32'hF000_0000 + 32'(i)); end
    end
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (bekleyen_sayisi_o !== 3'd0) begin failures++; $display("FAIL full_bekleyen0: got %0d expected 0", bekleyen_sayisi_o); end
  endtask

  task automatic test_flush();
    g2_hazir_i = 1'b0;
    istek_ver(32'h120); istek_ver(32'h124); istek_ver(32'h128);
    checks++; if (g2_gecerli_o !== 1'b1) begin failures++; $display("FAIL flush_held_before: got %b expected 1", g2_gecerli_o); end
    bosalt_i = 1'b1; g1_istek_gecerli_i = 1'b1; g1_istek_ps_i = 32'h999;
    #1;
    checks++; if (g1_istek_hazir_o !== 1'b0 || l1b_istek_gecerli_o !== 1'b0) begin
      failures++; $display("FAIL flush_issue_block: got hazir=%b gecerli=%b expected 0 0", g1_istek_hazir_o, l1b_istek_gecerli_o); end
    adim();
    bosalt_i = 1'b0; g1_istek_gecerli_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b0 || bekleyen_sayisi_o !== 3'd3) begin
      failures++; $display("FAIL flush_state: got v=%b cnt=%0d expected 0 3", g2_gecerli_o, bekleyen_sayisi_o); end
    istek_ver(32'h200);
    l1b_yanit_gecerli_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      l1b_yanit_veri_i = 32'hBAD0_0000 + 32'(i);
      #1;
      checks++; if (l1b_yanit_hazir_o !== 1'b1) begin failures++; $display("FAIL flush_drop_hazir%0d: got %b expected 1", i, l1b_yanit_hazir_o); end
      adim();
      checks++; if (g2_gecerli_o !== 1'b0) begin failures++; $display("FAIL flush_drop%0d: got %b expected 0", i, g2_gecerli_o); end
    end
    l1b_yanit_veri_i = 32'hAAAA_5555;
    adim();
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h200 || g2_buyruk_o !== 32'hAAAA_5555) begin
      failures++; $display("FAIL flush_live: got v=%b ps=%h d=%h expected 1 200 aaaa5555", g2_gecerli_o, g2_ps_o, g2_buyruk_o); end
    g2_hazir_i = 1'b1;
    adim();
  endtask

  task automatic test_flush_same_cycle();
    istek_ver(32'h400); istek_ver(32'h404);
    l1b_yanit_gecerli_i = 1'b1; l1b_yanit_veri_i = 32'h4444_0000; bosalt_i = 1'b1;
    #1;
    checks++; if (l1b_yanit_hazir_o !== 1'b1) begin failures++; $display("FAIL sc_flush_hazir: got %b expected 1", l1b_yanit_hazir_o); end
    adim();
    bosalt_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b0 || bekleyen_sayisi_o !== 3'd1) begin
      failures++; $display("FAIL sc_flush_drop1: got v=%b cnt=%0d expected 0 1", g2_gecerli_o, bekleyen_sayisi_o); end
    l1b_yanit_veri_i = 32'h4444_0001;
    adim();
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b0 || bekleyen_sayisi_o !== 3'd0) begin
      failures++; $display("FAIL sc_flush_drop2: got v=%b cnt=%0d expected 0 0", g2_gecerli_o, bekleyen_sayisi_o); end
    istek_ver(32'h408);
    l1b_yanit_gecerli_i = 1'b1; l1b_yanit_veri_i = 32'h77;
    adim();
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h408 || g2_buyruk_o !== 32'h77) begin
      failures++; $display("FAIL sc_flush_live: got v=%b ps=%h d=%h expected 1 408 77", g2_gecerli_o, g2_ps_o, g2_buyruk_o); end
    adim();
  endtask

  task automatic test_backpressure();
    istek_ver(32'h500); istek_ver(32'h504);
    l1b_yanit_gecerli_i = 1'b1; l1b_yanit_veri_i = 32'h11;
    adim();
    g2_hazir_i = 1'b0; l1b_yanit_veri_i = 32'h22;
    #1;
    checks++; if (l1b_yanit_hazir_o !== 1'b0) begin failures++; $display("FAIL bp_hazir_low: got %b expected 0", l1b_yanit_hazir_o); end
    adim(); adim();
    checks++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h500 || g2_buyruk_o !== 32'h11 || bekleyen_sayisi_o !== 3'd1) begin
      failures++; $display("FAIL bp_hold: got v=%b ps=%h d=%h cnt=%0d expected 1 500 11 1", g2_gecerli_o, g2_ps_o, g2_buyruk_o, bekleyen_sayisi_o); end
    g2_hazir_i = 1'b1;
    #1;
    checks++; if (l1b_yanit_hazir_o !== 1'b1) begin failures++; $display("FAIL bp_hazir_high: got %b expected 1", l1b_yanit_hazir_o); end
    adim();
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b1 || g2_ps_o !== 32'h504 || g2_buyruk_o !== 32'h22) begin
      failures++; $display("FAIL bp_next: got v=%b ps=%h d=%h expected 1 504 22", g2_gecerli_o, g2_ps_o, g2_buyruk_o); end
    adim();
  endtask

  task automatic test_async_reset();
    istek_ver(32'h600); istek_ver(32'h604); istek_ver(32'h608);
    l1b_yanit_gecerli_i = 1'b1; l1b_yanit_veri_i = 32'h66;
    adim();
    l1b_yanit_gecerli_i = 1'b0; g2_hazir_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b1 || bekleyen_sayisi_o !== 3'd2) begin
      failures++; $display("FAIL ar_pre: got v=%b cnt=%0d expected 1 2", g2_gecerli_o, bekleyen_sayisi_o); end
    #2;
    rst_i = 1'b1;
    #1;
    l1b_yanit_gecerli_i = 1'b1;
    #1;
    checks++; if (g2_gecerli_o !== 1'b0 || g2_ps_o !== 32'h0 || g2_buyruk_o !== 32'h0 || bekleyen_sayisi_o !== 3'd0 || l1b_yanit_hazir_o !== 1'b0) begin
      failures++; $display("FAIL ar_immediate: got v=%b ps=%h d=%h cnt=%0d hazir=%b expected 0 0 0 0 0", g2_gecerli_o, g2_ps_o, g2_buyruk_o, bekleyen_sayisi_o, l1b_yanit_hazir_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    g2_hazir_i = 1'b1;
    #1;
    checks++; if (l1b_yanit_hazir_o !== 1'b0) begin failures++; $display("FAIL ar_post_hazir: got %b expected 0", l1b_yanit_hazir_o); end
    adim();
    l1b_yanit_gecerli_i = 1'b0;
    checks++; if (g2_gecerli_o !== 1'b0 || bekleyen_sayisi_o !== 3'd0) begin
      failures++; $display("FAIL ar_post_state: got v=%b cnt=%0d expected 0 0", g2_gecerli_o, bekleyen_sayisi_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_flush_same_cycle();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/getir_istek_denetleyici.md
# getir_istek_denetleyici

Fetch request scheduler between fetch stage 1 and the L1 instruction cache (L1B). It issues fetch PCs to L1B under a credit limit and records each issued PC in an in-order tag FIFO. It pairs every L1B response with its PC and forwards it to fetch stage 2 through a registered output. On a pipeline flush it silently drains responses to requests issued before the flush, so stage 2 never sees stale instructions.

## Interface
- PS_BIT, 32, program counter width
- VERI_BIT, 32, L1B response data width
- MAKS_BEKLEYEN, 4, maximum outstanding L1B requests; power of two, ≥2
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- g1_istek_ps_i  in  PS_BIT  fetch PC from stage 1
- g1_istek_gecerli_i  in  1  stage-1 request valid
- g1_istek_hazir_o  out  1  request accepted this cycle
- l1b_istek_ps_o  out  PS_BIT  PC to L1B (= g1_istek_ps_i)
- l1b_istek_gecerli_o  out  1  request valid to L1B
- l1b_istek_hazir_i  in  1  L1B accepts request
- l1b_yanit_veri_i  in  VERI_BIT  L1B response data
- l1b_yanit_gecerli_i  in  1  response valid
- l1b_yanit_hazir_o  out  1  response accepted
- g2_buyruk_o  out  VERI_BIT  response data to stage 2
- g2_ps_o  out  PS_BIT  PC paired with g2_buyruk_o
- g2_gecerli_o  out  1  stage-2 output valid
- g2_hazir_i  in  1  stage 2 consumes output
- bosalt_i  in  1  flush: all outstanding requests become stale
- bekleyen_sayisi_o  out  $clog2(MAKS_BEKLEYEN+1)  outstanding count, stale included

## Operation
- Counters: bekleyen (outstanding), bayat (stale, always ≤ bekleyen). Tag FIFO depth MAKS_BEKLEYEN holds PCs. Read and write pointers wrap modulo MAKS_BEKLEYEN.
- Issue: dolu = (bekleyen == MAKS_BEKLEYEN).
  - l1b_istek_gecerli_o = g1_istek_gecerli_i & !dolu & !bosalt_i
  - g1_istek_hazir_o = l1b_istek_hazir_i & !dolu & !bosalt_i
  - Issue fires when l1b_istek_gecerli_o & l1b_istek_hazir_i. On fire: push PC, bekleyen+1.
- Response: l1b_yanit_hazir_o = (bekleyen != 0) & (bosalt_i | bayat != 0 | !g2_gecerli_o | g2_hazir_i).
  - Response fires when l1b_yanit_gecerli_i & l1b_yanit_hazir_o. On fire: pop FIFO, bekleyen−1.
  - If bayat != 0 or bosalt_i, the response is discarded and bayat decrements (when bayat != 0).
  - Otherwise data and the popped PC load the output register and g2_gecerli_o is set.
- Output register holds its value while g2_gecerli_o & !g2_hazir_i. It clears on consume when there is no new load.
- States:
  - BOSTA: bekleyen == 0
  - BEKLE: bekleyen > 0, bayat == 0
  - BOSALT: bayat > 0
  - Transitions follow the next-state counter values.
- Flush (bosalt_i): bayat_next = bekleyen − (response fires ? 1 : 0), issue is blocked, and g2_gecerli_o clears next cycle. Flush during BOSALT restarts bayat from current bekleyen by the same rule.
- Simultaneous issue and response: bekleyen unchanged. Pushes and pops both take effect.
- A response while bekleyen == 0 is a protocol violation. hazir stays low and no state changes.
- Full state blocks issue even if a response fires the same cycle; there is no same-cycle credit bypass.

## Timing
- Reset (async, while rst_i high): counters and pointers 0, state BOSTA, g2_gecerli_o 0, g2_buyruk_o 0, g2_ps_o 0. Combinational outputs evaluate with zero state, so l1b_yanit_hazir_o is 0.
- Issue path is fully combinational, zero latency.
- Response to g2_gecerli_o: 1 cycle.
- Back-to-back responses run at 1 per cycle when g2_hazir_i is held high.
- Flush takes effect in the same cycle for hazir/gecerli gating. Counter and output changes are visible the next cycle.
- Reset asserted mid-operation drops all state immediately. No stale tracking survives reset.

## Test plan
- Issue PCs 0x100, 0x104, 0x108, then respond with D0, D1, D2 and g2_hazir_i=1 → g2 outputs (0x100,D0), (0x104,D1), (0x108,D2) on consecutive cycles, one cycle after each response; bekleyen returns to 0.
- Issue 4 requests with L1B withholding responses → bekleyen_sayisi_o=4; 5th request sees g1_istek_hazir_o=0 and l1b_istek_gecerli_o=0. One response the same cycle still leaves issue blocked; issue resumes next cycle.
- 3 outstanding, pulse bosalt_i, then issue 0x200 → next 3 responses are discarded with g2_gecerli_o=0; the 4th response is output as (0x200, data).
- bosalt_i in the same cycle as a response with 2 outstanding → that response is discarded, bayat=1, and the following response is also discarded.
- g2_hazir_i=0 with g2_gecerli_o=1 and a response pending → l1b_yanit_hazir_o=0 and output held stable; raising g2_hazir_i accepts the response the same cycle.
- Assert rst_i asynchronously mid-burst with 2 outstanding → all outputs and bekleyen_sayisi_o are 0 immediately, and the first post-reset response is not accepted.
